// File: rtl/tsi_pkg.sv
// Shared definitions for the TSI target-side responder: FSM states,
// command encodings and word/address constants.
package tsi_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] CMD_READ  = 32'd0;
  localparam logic [WORD_W-1:0] CMD_WRITE = 32'd1;

  localparam logic [63:0] ADDR_INC = 64'd4;

  typedef enum logic [3:0] {
    ST_CMD,
    ST_ADDR_LO,
    ST_ADDR_HI,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_WDATA,
    ST_WREQ,
    ST_RREQ,
    ST_RWAIT,
    ST_RSEND
  } state_e;

endpackage

// File: rtl/tsi_responder.sv
// TSI target endpoint: decodes host command streams into single-word memory
// reads/writes and returns read data. TSI_RESP_ERR_CNT_EN adds err_count.
module tsi_responder
  import tsi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = WORD_W
) (
`ifdef TSI_RESP_ERR_CNT_EN
  output logic [15:0]       err_count,
`endif
  input  logic              clock,
  input  logic              reset,
  input  logic              serial_in_valid,
  output logic              serial_in_ready,
  input  logic [DATA_W-1:0] serial_in_bits,
  output logic              serial_out_valid,
  input  logic              serial_out_ready,
  output logic [DATA_W-1:0] serial_out_bits,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
);

  state_e            state_q, state_d;
  logic [63:0]       addr_q, addr_d;
  logic [32:0]       count_q, count_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              is_write_q, is_write_d;
  logic              in_ready_q, in_ready_d;
  logic              req_valid_q, req_valid_d;
  logic              req_write_q, req_write_d;
  logic              out_valid_q, out_valid_d;
  logic              in_fire;

`ifdef TSI_RESP_ERR_CNT_EN
  logic [15:0]       err_cnt_q, err_cnt_d;
  assign err_count = err_cnt_q;
`endif

  assign serial_in_ready  = in_ready_q;
  assign serial_out_valid = out_valid_q;
  assign serial_out_bits  = rdata_q;
  assign mem_req_valid    = req_valid_q;
  assign mem_req_write    = req_write_q;
  assign mem_req_addr     = addr_q[ADDR_W-1:0];
  assign mem_req_data     = wdata_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    is_write_d = is_write_q;
    in_fire    = in_ready_q && serial_in_valid;
`ifdef TSI_RESP_ERR_CNT_EN
    err_cnt_d  = err_cnt_q;
`endif

    unique case (state_q)
      ST_CMD: begin
        if (in_fire) begin
          if (serial_in_bits == CMD_READ || serial_in_bits == CMD_WRITE) begin
            is_write_d = (serial_in_bits == CMD_WRITE);
            state_d    = ST_ADDR_LO;
          end else begin
`ifdef TSI_RESP_ERR_CNT_EN
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
`endif
          end
        end
      end
      ST_ADDR_LO: begin
        if (in_fire) begin
          addr_d[31:0] = serial_in_bits;
          state_d      = ST_ADDR_HI;
        end
      end
      ST_ADDR_HI: begin
        if (in_fire) begin
          addr_d[63:32] = serial_in_bits;
          state_d       = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        // 33-bit count so that LEN_LO = all-ones still means 2^32 words
        if (in_fire) begin
          count_d = {1'b0, serial_in_bits} + 33'd1;
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (in_fire) state_d = is_write_q ? ST_WDATA : ST_RREQ;
      end
      ST_WDATA: begin
        if (in_fire) begin
          wdata_d = serial_in_bits;
          state_d = ST_WREQ;
        end
      end
      ST_WREQ: begin
        if (mem_req_ready) begin
          addr_d  = addr_q + ADDR_INC;
          count_d = count_q - 33'd1;
          state_d = (count_q == 33'd1) ? ST_CMD : ST_WDATA;
        end
      end
      ST_RREQ: begin
        if (mem_req_ready) state_d = ST_RWAIT;
      end
      ST_RWAIT: begin
        if (mem_resp_valid) begin
          rdata_d = mem_resp_data;
          state_d = ST_RSEND;
        end
      end
      ST_RSEND: begin
        if (serial_out_ready) begin
          addr_d  = addr_q + ADDR_INC;
          count_d = count_q - 33'd1;
          state_d = (count_q == 33'd1) ? ST_CMD : ST_RREQ;
        end
      end
      default: state_d = ST_CMD;
    endcase

    // Handshake outputs are registered copies of the next-state decode
    in_ready_d  = state_d inside {ST_CMD, ST_ADDR_LO, ST_ADDR_HI, ST_LEN_LO,
                                  ST_LEN_HI, ST_WDATA};
    req_valid_d = state_d inside {ST_WREQ, ST_RREQ};
    req_write_d = (state_d == ST_WREQ);
    out_valid_d = (state_d == ST_RSEND);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_CMD;
      addr_q      <= '0;
      count_q     <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      is_write_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef TSI_RESP_ERR_CNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      is_write_q  <= is_write_d;
      in_ready_q  <= in_ready_d;
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      out_valid_q <= out_valid_d;
`ifdef TSI_RESP_ERR_CNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

endmodule
